// File: rtl/gray_pkg.sv
// Shared types and default widths for the Gray step decoder and its helpers.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF     = 4;
    localparam int GRAY_ERR_CNT_W_DEF = 8;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } gray_state_e;

    typedef struct packed {
        logic up;
        logic dn;
        logic err;
        logic wrap;
    } step_flags_t;

endpackage

// File: rtl/gray_step_decoder_if.sv
// Sample-in / decode-out bundle for gray_step_decoder; slave side is the decoder.
interface gray_step_decoder_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     gray_in;
    logic                 in_valid;
    logic                 resync;
    logic [WIDTH-1:0]     bin_out;
    logic                 out_valid;
    logic                 step_up;
    logic                 step_dn;
    logic                 step_err;
    logic                 wrap;
    logic                 synced;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  gray_in, in_valid, resync,
        output bin_out, out_valid, step_up, step_dn, step_err, wrap, synced, err_count
    );

    modport master (
        output gray_in, in_valid, resync,
        input  bin_out, out_valid, step_up, step_dn, step_err, wrap, synced, err_count
    );
endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end
endmodule

// File: rtl/gray_step_decoder.sv
// Two-stage Gray count decoder with step/wrap/error classification.
// Define GRAY_ERR_CNT_EN to build the saturating step-error counter; otherwise err_count is tied 0.
module gray_step_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH     = GRAY_WIDTH_DEF,
    parameter int ERR_CNT_W = GRAY_ERR_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    gray_step_decoder_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1 = '1;

    logic              s1_vld_q;
    logic [WIDTH-1:0]  s1_gray_q;
    logic [WIDTH-1:0]  cur_bin;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  delta;
    logic              s2_take;
    gray_state_e       state_q, state_d;
    logic              out_valid_q, out_valid_d;
    step_flags_t       flags_q, flags_d;

    // Stage 1: resync squashes a sample arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_gray_q <= '0;
        end else begin
            s1_vld_q <= bus.in_valid && !bus.resync;
            if (bus.in_valid) s1_gray_q <= bus.gray_in;
        end
    end

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray_i (s1_gray_q),
        .bin_o  (cur_bin)
    );

    // Resync also drops whatever is sitting in stage 1.
    assign s2_take = s1_vld_q && !bus.resync;
    assign delta   = cur_bin - prev_q;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= UNSYNC;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.resync)                       state_d = UNSYNC;
        else if (s2_take && state_q == UNSYNC) state_d = TRACK;
    end

    always_comb begin
        out_valid_d = s2_take;
        flags_d     = '0;
        if (s2_take && state_q == TRACK) begin
            if (delta == ONE) begin
                flags_d.up   = 1'b1;
                flags_d.wrap = (prev_q == ALL1);
            end else if (delta == ALL1) begin
                flags_d.dn   = 1'b1;
                flags_d.wrap = (prev_q == '0);
            end else if (delta != '0) begin
                flags_d.err  = 1'b1;
            end
        end
    end

    // Stage 2 registers; prev doubles as the held bin_out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            prev_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            if (s2_take) prev_q <= cur_bin;
        end
    end

`ifdef GRAY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (flags_d.err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) err_cnt_q <= '0;
        else      err_cnt_q <= err_cnt_d;
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = {ERR_CNT_W{1'b0}};
`endif

    assign bus.bin_out   = prev_q;
    assign bus.out_valid = out_valid_q;
    assign bus.step_up   = flags_q.up;
    assign bus.step_dn   = flags_q.dn;
    assign bus.step_err  = flags_q.err;
    assign bus.wrap      = flags_q.wrap;
    assign bus.synced    = (state_q == TRACK);

endmodule

// File: tb/tb_gray_step_decoder.sv
// Scoreboard bench for gray_step_decoder: directed samples push expectations, a negedge monitor pops and compares.
module tb_gray_step_decoder;

    localparam int W  = 4;
    localparam int EW = 8;

    typedef struct {
        logic [W-1:0]  bin;
        logic          up;
        logic          dn;
        logic          err;
        logic          wrap;
        logic          synced;
        logic [EW-1:0] errcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   model_err = 0;
    logic [W-1:0] last_bin = '0;
    exp_t q[$];

    gray_step_decoder_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

    gray_step_decoder #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [W-1:0] g, input logic [W-1:0] b,
                        input logic up, input logic dn, input logic err, input logic wrap,
                        input logic push);
        exp_t e;
        bus.gray_in  = g;
        bus.in_valid = 1'b1;
        if (push) begin
`ifdef GRAY_ERR_CNT_EN
            if (err && model_err != 255) model_err++;
`endif
            e.bin = b; e.up = up; e.dn = dn; e.err = err; e.wrap = wrap;
            e.synced = 1'b1; e.errcnt = EW'(model_err);
            q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every out_valid, check hold/quiet otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last_bin = '0;
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got bin %0d expected no output at %0t", bus.bin_out, $time);
            end else begin
                e = q.pop_front();
                chk("bin_out",   32'(bus.bin_out),   32'(e.bin));
                chk("step_up",   32'(bus.step_up),   32'(e.up));
                chk("step_dn",   32'(bus.step_dn),   32'(e.dn));
                chk("step_err",  32'(bus.step_err),  32'(e.err));
                chk("wrap",      32'(bus.wrap),      32'(e.wrap));
                chk("synced",    32'(bus.synced),    32'(e.synced));
                chk("err_count", 32'(bus.err_count), 32'(e.errcnt));
                last_bin = e.bin;
            end
        end else begin
            chk("idle_flags", {28'd0, bus.step_up, bus.step_dn, bus.step_err, bus.wrap}, 32'd0);
            chk("bin_hold",   32'(bus.bin_out), 32'(last_bin));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.gray_in  = '0;
        bus.in_valid = 1'b0;
        bus.resync   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        chk("rst_bin_out",   32'(bus.bin_out),   0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_synced",    32'(bus.synced),    0);
        chk("rst_err_count", 32'(bus.err_count), 0);

        // First sample: prime, and check two-clock latency.
        send(4'b0000, 4'd0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("lat_1clk_out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_2clk_out_valid", 32'(bus.out_valid), 1);

        send(4'b0001, 4'd1, 1, 0, 0, 0, 1);
        send(4'b0011, 4'd2, 1, 0, 0, 0, 1);
        send(4'b0010, 4'd3, 1, 0, 0, 0, 1);
        send(4'b0010, 4'd3, 0, 0, 0, 0, 1);
        send(4'b0011, 4'd2, 0, 1, 0, 0, 1);
        idle(3);

        // Sample in stage 1, then resync together with a new valid sample: both dropped.
        send(4'b0110, 4'd4, 0, 0, 0, 0, 0);
        bus.resync   = 1'b1;
        bus.in_valid = 1'b1;
        bus.gray_in  = 4'b0101;
        @(posedge clk); #1;
        bus.resync   = 1'b0;
        bus.in_valid = 1'b0;
        idle(2);
        chk("resync_unsynced", 32'(bus.synced), 0);

        send(4'b1000, 4'd15, 0, 0, 0, 0, 1);
        send(4'b0000, 4'd0,  1, 0, 0, 1, 1);
        send(4'b1000, 4'd15, 0, 1, 0, 1, 1);
        send(4'b0000, 4'd0,  1, 0, 0, 1, 1);
        send(4'b0011, 4'd2,  0, 0, 1, 0, 1);
        send(4'b0010, 4'd3,  1, 0, 0, 0, 1);
        idle(3);

        // Reset while a sample sits in stage 1.
        send(4'b0110, 4'd4, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_err = 0;
        @(negedge clk);
        chk("midrst_bin_out",   32'(bus.bin_out),   0);
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_synced",    32'(bus.synced),    0);
        chk("midrst_err_count", 32'(bus.err_count), 0);
        idle(3);

        send(4'b0111, 4'd5, 0, 0, 0, 0, 1);
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) send(4'b0000, 4'd0, 0, 0, 1, 0, 1);
            else            send(4'b0111, 4'd5, 0, 0, 1, 0, 1);
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_queue_empty", 32'(q.size()), 0);
`ifdef GRAY_ERR_CNT_EN
        chk("final_err_count", 32'(bus.err_count), 255);
`else
        chk("final_err_count", 32'(bus.err_count), 0);
`endif
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
